// File: rtl/htpa_bbox_if.sv
// htpa_bbox_if: HTPA pixel stream in, per-frame hot-pixel bounding box out
interface htpa_bbox_if #(
    parameter int PIX_W = 16
);
    logic             pix_valid;
    logic             pix_sof;
    logic [PIX_W-1:0] pix_data;
    logic [PIX_W-1:0] thr;
    logic [6:0]       xo;
    logic [6:0]       xn;
    logic [5:0]       yo;
    logic [5:0]       yn;
    logic             found;
    logic [12:0]      hit_cnt;
    logic             box_valid;
    logic             frame_err;
    modport master (
        output pix_valid, pix_sof, pix_data, thr,
        input  xo, xn, yo, yn, found, hit_cnt, box_valid, frame_err
    );
    modport slave (
        input  pix_valid, pix_sof, pix_data, thr,
        output xo, xn, yo, yn, found, hit_cnt, box_valid, frame_err
    );
endinterface

// File: rtl/htpa_bbox_find.sv
// htpa_bbox_find: thresholds a raster pixel stream and publishes the hot-pixel bounding box per frame
module htpa_bbox_find #(
    parameter int X_SIZE = 80,
    parameter int Y_SIZE = 64
) (
    input logic        clk,
    input logic        reset,
    htpa_bbox_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t      state_q;
    logic [6:0]  x_q, xmin_q, xmax_q, xo_q, xn_q;
    logic [5:0]  y_q, ymin_q, ymax_q, yo_q, yn_q;
    logic [12:0] cnt_q, hit_q;
    logic        any_q, found_q, box_q, err_q;
    logic        start, take, hot, wrap, last, any_d;
    logic [6:0]  cx, xmin_b, xmax_b, x_d, xmin_d, xmax_d;
    logic [5:0]  cy, ymin_b, ymax_b, y_d, ymin_d, ymax_d;
    logic [12:0] cnt_b, cnt_d;
    // A sof pixel is processed against freshly initialised accumulators in the same cycle
    always_comb begin
        start  = bus.pix_valid & bus.pix_sof;
        take   = start | (bus.pix_valid & (state_q == SCAN));
        hot    = bus.pix_valid & (bus.pix_data > bus.thr);
        cx     = start ? 7'd0 : x_q;
        cy     = start ? 6'd0 : y_q;
        xmin_b = start ? 7'd127 : xmin_q;
        xmax_b = start ? 7'd0 : xmax_q;
        ymin_b = start ? 6'd63 : ymin_q;
        ymax_b = start ? 6'd0 : ymax_q;
        cnt_b  = start ? 13'd0 : cnt_q;
        xmin_d = (hot && cx < xmin_b) ? cx : xmin_b;
        xmax_d = (hot && cx > xmax_b) ? cx : xmax_b;
        ymin_d = (hot && cy < ymin_b) ? cy : ymin_b;
        ymax_d = (hot && cy > ymax_b) ? cy : ymax_b;
        cnt_d  = cnt_b + 13'(hot && cnt_b != 13'h1fff);
        any_d  = hot | (~start & any_q);
        wrap   = cx == 7'(X_SIZE - 1);
        last   = wrap && cy == 6'(Y_SIZE - 1);
        x_d    = wrap ? 7'd0 : cx + 7'd1;
        y_d    = wrap ? cy + 6'd1 : cy;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            {x_q, y_q, xmin_q, xmax_q, ymin_q, ymax_q, cnt_q, any_q} <= '0;
            {xo_q, xn_q, yo_q, yn_q, hit_q, found_q, box_q, err_q} <= '0;
        end else begin
            box_q <= 1'b0;
            err_q <= 1'b0;
            if (take) begin
                state_q <= last ? DONE : SCAN;
                x_q     <= x_d;
                y_q     <= y_d;
                xmin_q  <= xmin_d;
                xmax_q  <= xmax_d;
                ymin_q  <= ymin_d;
                ymax_q  <= ymax_d;
                cnt_q   <= cnt_d;
                any_q   <= any_d;
                err_q   <= start & (state_q == SCAN);
                if (last) begin
                    box_q   <= 1'b1;
                    found_q <= any_d;
                    xo_q    <= any_d ? xmin_d : 7'd0;
                    xn_q    <= any_d ? xmax_d : 7'd0;
                    yo_q    <= any_d ? ymin_d : 6'd0;
                    yn_q    <= any_d ? ymax_d : 6'd0;
                    hit_q   <= cnt_d;
                end
            end else if (state_q == DONE) begin
                state_q <= IDLE;
            end
        end
    end
    assign bus.xo        = xo_q;
    assign bus.xn        = xn_q;
    assign bus.yo        = yo_q;
    assign bus.yn        = yn_q;
    assign bus.found     = found_q;
    assign bus.hit_cnt   = hit_q;
    assign bus.box_valid = box_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_htpa_bbox_find.sv
// tb_htpa_bbox_find: table vectors, random frames vs. an array model, abort and mid-frame reset
module tb_htpa_bbox_find;
    localparam int X = 80;
    localparam int Y = 64;
    localparam int NPIX = X * Y;
    typedef struct {
        int h0, h1, h2, bg, hv, th, f, xo, xn, yo, yn, hit;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int img [NPIX];
    vec_t tbl [6];
    int checks = 0, errors = 0, box_cnt = 0, err_cnt = 0, both_cnt = 0;
    htpa_bbox_if #(.PIX_W(16)) bus ();
    htpa_bbox_find #(.X_SIZE(X), .Y_SIZE(Y)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.box_valid) box_cnt <= box_cnt + 1;
        if (bus.frame_err) err_cnt <= err_cnt + 1;
        if (bus.box_valid && bus.frame_err) both_cnt <= both_cnt + 1;
    end
    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", n, got, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send(input bit sof, input int d);
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.pix_data  = 16'(d);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask
    task automatic check_box(input string n, input int f, xo, xn, yo, yn, hit);
        chk({n, " found"}, int'(bus.found), f);
        chk({n, " xo"}, int'(bus.xo), xo);
        chk({n, " xn"}, int'(bus.xn), xn);
        chk({n, " yo"}, int'(bus.yo), yo);
        chk({n, " yn"}, int'(bus.yn), yn);
        chk({n, " hit_cnt"}, int'(bus.hit_cnt), hit);
    endtask
    task automatic build(input vec_t v);
        for (int i = 0; i < NPIX; i++) img[i] = v.bg;
        if (v.h0 >= 0) img[v.h0] = v.hv;
        if (v.h1 >= 0) img[v.h1] = v.hv;
        if (v.h2 >= 0) img[v.h2] = v.hv;
    endtask
    // Sends pixels first..NPIX-1 (pixel 0 carries sof) and checks the publish that follows
    task automatic run_frame(input string n, input int first, gap, f, xo, xn, yo, yn, hit);
        int b0;
        b0 = box_cnt;
        for (int i = first; i < NPIX; i++) begin
            if (gap > 0) idle(int'($urandom_range(0, gap)));
            send(i == 0, img[i]);
        end
        chk({n, " latency"}, int'(bus.box_valid), 1);
        check_box(n, f, xo, xn, yo, yn, hit);
        idle(1);
        chk({n, " pulse"}, int'(bus.box_valid), 0);
        chk({n, " count"}, box_cnt - b0, 1);
    endtask
    task automatic model(input int t, output int f, xo, xn, yo, yn, hit);
        int n = 0, a = 127, b = 0, c = 63, d = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (img[i] > t) begin
                n++;
                a = (i % X < a) ? i % X : a;
                b = (i % X > b) ? i % X : b;
                c = (i / X < c) ? i / X : c;
                d = (i / X > d) ? i / X : d;
            end
        end
        f   = (n > 0) ? 1 : 0;
        xo  = (n > 0) ? a : 0;
        xn  = (n > 0) ? b : 0;
        yo  = (n > 0) ? c : 0;
        yn  = (n > 0) ? d : 0;
        hit = (n > 8191) ? 8191 : n;
    endtask
    task automatic model_run(input string n, input int first, gap);
        int f, xo, xn, yo, yn, hit;
        model(int'(bus.thr), f, xo, xn, yo, yn, hit);
        run_frame(n, first, gap, f, xo, xn, yo, yn, hit);
    endtask
    initial begin
        int b0, e0;
        tbl[0] = '{-1, -1, -1, 100, 0, 200, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{410, 2420, 5119, 100, 500, 200, 1, 10, 79, 5, 63, 3};
        tbl[2] = '{0, -1, -1, 100, 500, 200, 1, 0, 0, 0, 0, 1};
        tbl[3] = '{-1, -1, -1, 200, 0, 200, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{-1, -1, -1, 201, 0, 200, 1, 0, 79, 0, 63, 5120};
        tbl[5] = '{5119, -1, -1, 0, 65535, 65534, 1, 79, 79, 63, 63, 1};
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = '0;
        bus.thr       = '0;
        idle(3);
        reset = 1'b0;
        idle(1);
        check_box("reset", 0, 0, 0, 0, 0, 0);
        chk("reset box_valid", int'(bus.box_valid), 0);
        chk("reset frame_err", int'(bus.frame_err), 0);
        for (int r = 0; r < 6; r++) begin
            build(tbl[r]);
            bus.thr = 16'(tbl[r].th);
            run_frame($sformatf("vec%0d", r), 0, 0, tbl[r].f, tbl[r].xo, tbl[r].xn,
                      tbl[r].yo, tbl[r].yn, tbl[r].hit);
        end
        build(tbl[1]);
        bus.thr = 16'd200;
        run_frame("gaps", 0, 3, 1, 10, 79, 5, 63, 3);
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 65535));
        bus.thr = 16'd65000;
        model_run("randA", 0, 0);
        build(tbl[1]);
        bus.thr = 16'd200;
        run_frame("pre", 0, 0, 1, 10, 79, 5, 63, 3);
        b0 = box_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 1000; i++) send(i == 0, 60000);
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 210));
        send(1'b1, img[0]);
        chk("abort frame_err", int'(bus.frame_err), 1);
        chk("abort box_valid", int'(bus.box_valid), 0);
        check_box("abort hold", 1, 10, 79, 5, 63, 3);
        idle(1);
        chk("abort err pulse", int'(bus.frame_err), 0);
        model_run("restart", 1, 0);
        chk("abort err count", err_cnt - e0, 1);
        chk("abort box count", box_cnt - b0, 1);
        for (int i = 0; i < NPIX; i++) img[i] = 500;
        for (int i = 0; i < 2000; i++) send(i == 0, img[i]);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_box("midreset", 0, 0, 0, 0, 0, 0);
        b0 = box_cnt;
        for (int i = 2000; i < NPIX; i++) send(1'b0, img[i]);
        idle(2);
        chk("midreset no box", box_cnt - b0, 0);
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 300));
        bus.thr = 16'd290;
        model_run("post", 0, 1);
        chk("box/err exclusive", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
